// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arb_mux family: select-mode constants and an
// index-width helper that never returns less than one bit.
package arb_mux_pkg;

    localparam int SEL_EXT = 0;
    localparam int SEL_RR  = 1;

    // Width of an index able to address n items; a single item still gets 1 bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/arb_mux_n_rr_pick.sv
// Rotate-priority encoder: grants the first requester at or after ptr,
// wrapping modulo NUM_IN. Purely combinational so other arbiters can reuse it.
module rr_pick #(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_any
);

    // Scan from the farthest offset down so the nearest requester after ptr wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_IN;
            if (req[idx]) begin
                gnt_idx = SEL_W'(idx);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// N-way WIDTH-bit selector with a registered output stage and valid/ready on
// every channel. RR_MODE picks between external select and round-robin.
// Optional build macro ARB_MUX_STATS_EN adds a 32-bit output handshake counter.
module arb_mux_n
    import arb_mux_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int NUM_IN  = 4,
    parameter  int RR_MODE = 0,
    localparam int SEL_W   = clog2_min1(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef ARB_MUX_STATS_EN
    output logic [31:0]             xfer_cnt,
`endif
    output logic [SEL_W-1:0]        out_src
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_any;
    logic [SEL_W-1:0] g;
    logic             gnt_ok;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    rr_pick #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_rr_pick (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    assign load_en = !out_valid || out_ready;

    // Resolve the granted channel; an out-of-range sel grants nothing.
    always_comb begin
        g      = '0;
        gnt_ok = 1'b0;
        if (RR_MODE == SEL_RR) begin
            g      = rr_idx;
            gnt_ok = rr_any;
        end else begin
            g      = sel;
            gnt_ok = ({1'b0, sel} < (SEL_W + 1)'(NUM_IN));
        end
    end

    // One-hot ready toward the granted channel and its data word.
    always_comb begin
        in_ready = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready[i] = !rst && gnt_ok && load_en && (g == SEL_W'(i));
            if (g == SEL_W'(i)) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = |(in_valid & in_ready);

    // Output register and round-robin pointer; both hold while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= sel_data;
                out_src  <= g;
                ptr      <= (g == SEL_W'(NUM_IN - 1)) ? '0 : g + SEL_W'(1);
            end
        end
    end

`ifdef ARB_MUX_STATS_EN
    // Count accepted output words; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (out_valid && out_ready) begin
            xfer_cnt <= xfer_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: one external-select and one round-robin instance share
// stimulus; a per-instance reference model pushes expected words to a queue on
// predicted transfers and pops them on output handshakes.
module tb_arb_mux_n;

    localparam int W = 32;
    localparam int N = 4;
    localparam int SW = 2;
    localparam logic [N-1:0] ONE = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [SW-1:0]  sel;
    logic           out_ready;

    logic [N-1:0]  e_in_ready, r_in_ready;
    logic [W-1:0]  e_out_data, r_out_data;
    logic          e_out_valid, r_out_valid;
    logic [SW-1:0] e_out_src, r_out_src;
`ifdef ARB_MUX_STATS_EN
    logic [31:0]   e_cnt, r_cnt;
`endif

    arb_mux_n #(.WIDTH(W), .NUM_IN(N), .RR_MODE(0)) u_ext (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (e_in_ready),
        .sel       (sel),
        .out_data  (e_out_data),
        .out_valid (e_out_valid),
        .out_ready (out_ready),
`ifdef ARB_MUX_STATS_EN
        .xfer_cnt  (e_cnt),
`endif
        .out_src   (e_out_src)
    );

    arb_mux_n #(.WIDTH(W), .NUM_IN(N), .RR_MODE(1)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (r_in_ready),
        .sel       (sel),
        .out_data  (r_out_data),
        .out_valid (r_out_valid),
        .out_ready (out_ready),
`ifdef ARB_MUX_STATS_EN
        .xfer_cnt  (r_cnt),
`endif
        .out_src   (r_out_src)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [SW+W-1:0] qe[$];
    logic [SW+W-1:0] qr[$];
    int              rr_seen[$];
    logic            me_valid, mr_valid;
    int              mr_ptr;
    logic [31:0]     me_cnt, mr_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic [N-1:0] v, input logic [SW-1:0] s,
                         input logic ordy, input bit keep);
        logic [N-1:0] er_e, er_r;
        logic         le_e, le_r, xe, xr;
        bit           fr;
        int           gr;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        sel       = s;
        out_ready = ordy;
        if (!keep) begin
            for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
        end
        #1;

        // external-select model
        le_e = !me_valid || ordy;
        er_e = (!r && le_e) ? (ONE << s) : '0;
        check("ext_in_ready", e_in_ready, er_e);
        check("ext_out_valid", e_out_valid, me_valid);
`ifdef ARB_MUX_STATS_EN
        check("ext_xfer_cnt", e_cnt, me_cnt);
`endif
        if (me_valid) begin
            check("ext_sb_size", qe.size(), 1);
            if (qe.size() > 0) begin
                check("ext_out_data", e_out_data, qe[0][W-1:0]);
                check("ext_out_src", e_out_src, qe[0][SW+W-1:W]);
            end
        end
        xe = |(er_e & v);
        if (r) begin
            me_valid = 1'b0;
            qe.delete();
            me_cnt = '0;
        end else begin
            if (me_valid && ordy) begin
                me_cnt++;
                if (qe.size() > 0) void'(qe.pop_front());
            end
            if (le_e) me_valid = xe;
            if (xe) qe.push_back({s, in_data[s*W +: W]});
        end

        // round-robin model
        le_r = !mr_valid || ordy;
        fr = 1'b0;
        gr = 0;
        for (int k = 0; k < N; k++) begin
            if (!fr && v[(mr_ptr + k) % N]) begin
                fr = 1'b1;
                gr = (mr_ptr + k) % N;
            end
        end
        er_r = (!r && le_r && fr) ? (ONE << gr) : '0;
        check("rr_in_ready", r_in_ready, er_r);
        check("rr_out_valid", r_out_valid, mr_valid);
`ifdef ARB_MUX_STATS_EN
        check("rr_xfer_cnt", r_cnt, mr_cnt);
`endif
        if (mr_valid) begin
            check("rr_sb_size", qr.size(), 1);
            if (qr.size() > 0) begin
                check("rr_out_data", r_out_data, qr[0][W-1:0]);
                check("rr_out_src", r_out_src, qr[0][SW+W-1:W]);
            end
        end
        xr = !r && le_r && fr;
        if (r) begin
            mr_valid = 1'b0;
            mr_ptr   = 0;
            qr.delete();
            mr_cnt = '0;
        end else begin
            if (mr_valid && ordy) begin
                mr_cnt++;
                rr_seen.push_back(int'(r_out_src));
                if (qr.size() > 0) void'(qr.pop_front());
            end
            if (le_r) mr_valid = xr;
            if (xr) begin
                qr.push_back({SW'(gr), in_data[gr*W +: W]});
                mr_ptr = (gr + 1) % N;
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; sel = '0; out_ready = 1'b0; in_data = '0;
        me_valid = 1'b0; mr_valid = 1'b0; mr_ptr = 0; me_cnt = '0; mr_cnt = '0;

        // reset with every channel requesting
        repeat (2) cycle(1'b1, 4'hF, 2'd0, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("rst_ext_out_data", e_out_data, 0);
        check("rst_rr_out_data", r_out_data, 0);
        check("rst_ext_out_src", e_out_src, 0);
        check("rst_ext_out_valid", e_out_valid, 0);
        check("rst_rr_in_ready", r_in_ready, 0);

        // first accept right after reset: sel=2 carries 0xDEADBEEF
        for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
        in_data[2*W +: W] = 32'hDEADBEEF;
        cycle(1'b0, 4'b0100, 2'd2, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("ext_deadbeef", e_out_data, 32'hDEADBEEF);
        check("ext_src2", e_out_src, 2);
        check("rr_src2", r_out_src, 2);

        // backpressure for 3 cycles, then release loads the next word at once
        repeat (3) cycle(1'b0, 4'hF, 2'd1, 1'b0, 1'b0);
        cycle(1'b0, 4'hF, 2'd1, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("bp_ext_src", e_out_src, 1);
        check("bp_rr_src", r_out_src, 3);
        check("bp_ext_valid", e_out_valid, 1);

        // mixed random traffic
        repeat (40) cycle(1'b0, N'($urandom), SW'($urandom), $urandom_range(0, 3) != 0, 1'b0);

        // round-robin fairness with all channels valid
        cycle(1'b1, 4'h0, 2'd0, 1'b1, 1'b0);
        rr_seen.delete();
        repeat (8) cycle(1'b0, 4'hF, 2'd0, 1'b1, 1'b0);
        cycle(1'b0, 4'h0, 2'd0, 1'b1, 1'b0);
        check("rr_fair_len", rr_seen.size(), 8);
        for (int i = 0; i < 8 && i < rr_seen.size(); i++) check("rr_fair_seq", rr_seen[i], i % 4);

        // skip and wrap: move pointer to 3, then only channels 0 and 2 request
        cycle(1'b0, 4'b0100, 2'd0, 1'b1, 1'b0);
        cycle(1'b0, 4'b0101, 2'd0, 1'b1, 1'b0);
        rr_seen.delete();
        repeat (2) cycle(1'b0, 4'b0101, 2'd0, 1'b1, 1'b0);
        cycle(1'b0, 4'b0000, 2'd0, 1'b1, 1'b0);
        check("rr_skip_len", rr_seen.size(), 3);
        if (rr_seen.size() == 3) begin
            check("rr_skip_0", rr_seen[0], 0);
            check("rr_skip_1", rr_seen[1], 2);
            check("rr_skip_2", rr_seen[2], 0);
        end

        // reset while a word is held discards it
        cycle(1'b0, 4'hF, 2'd3, 1'b0, 1'b0);
        cycle(1'b0, 4'hF, 2'd3, 1'b0, 1'b0);
        cycle(1'b1, 4'hF, 2'd3, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("midrst_ext_valid", e_out_valid, 0);
        check("midrst_rr_valid", r_out_valid, 0);

        // streaming with two stall cycles interleaved
        for (int i = 0; i < 12; i++) cycle(1'b0, 4'hF, SW'(i), (i != 3 && i != 7), 1'b0);
        cycle(1'b0, 4'h0, 2'd0, 1'b1, 1'b0);
`ifdef ARB_MUX_STATS_EN
        @(posedge clk); #1;
        check("stats_ext_cnt", e_cnt, 32'd10);
        check("stats_rr_cnt", r_cnt, 32'd10);
        cycle(1'b1, 4'h0, 2'd0, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("stats_rst_cnt", e_cnt, 32'd0);
`endif
        cycle(1'b0, 4'h0, 2'd0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
